// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and SPI mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic CPOL_IDLE_LOW  = 1'b0;
  localparam logic CPOL_IDLE_HIGH = 1'b1;
  localparam logic CPHA_LEAD      = 1'b0;
  localparam logic CPHA_TRAIL     = 1'b1;

  localparam logic [1:0] MODE0 = {CPOL_IDLE_LOW,  CPHA_LEAD};
  localparam logic [1:0] MODE1 = {CPOL_IDLE_LOW,  CPHA_TRAIL};
  localparam logic [1:0] MODE2 = {CPOL_IDLE_HIGH, CPHA_LEAD};
  localparam logic [1:0] MODE3 = {CPOL_IDLE_HIGH, CPHA_TRAIL};

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle between a master and the slave, including the miso pad enable.
interface spi_slave_if;
  logic ss_n;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output ss_n, sclk, mosi, input miso, miso_oe);
  modport slave  (input ss_n, sclk, mosi, output miso, miso_oe);
endinterface

// File: rtl/sync_bit.sv
// SYNC-stage flip-flop synchronizer for one asynchronous input bit.
module sync_bit #(
  parameter int   SYNC    = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] stage_q;
  logic [SYNC-1:0] stage_d;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_d[gi] = d;
      end else begin : g_rest
        assign stage_d[gi] = stage_q[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q[gi] <= RST_VAL;
        else        stage_q[gi] <= stage_d[gi];
      end
    end
  endgenerate

  assign q = stage_q[SYNC-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four cpol/cpha modes, oversampling the SPI pins on the system clock.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpol,
  input  logic             cpha,
  spi_slave_if.slave       bus,
  input  logic [WIDTH-1:0] din,
  input  logic             din_we,
  output logic             tx_full,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             underrun,
  output logic             abort
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int FW = $clog2(SYNC + 1);

  logic s_ss_n, s_sclk, s_mosi;

  sync_bit #(.SYNC(SYNC), .RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst_n(rst_n), .d(bus.ss_n), .q(s_ss_n));
  sync_bit #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(bus.sclk), .q(s_sclk));
  sync_bit #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(bus.mosi), .q(s_mosi));

  state_e           state_q, state_d;
  logic             sclk_prev_q, sclk_prev_d;
  logic             ss_prev_q, ss_prev_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             tx_full_q, tx_full_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             underrun_q, underrun_d;
  logic             abort_q, abort_d;

  logic fill_done, ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  // The synchronizer reset value of ss_n is not a real observation, so select is
  // only armed once the pipeline has flushed and the pin has been seen high.
  assign fill_done   = (fill_q == FW'(SYNC));
  assign ss_fall     = armed_q && ss_prev_q && !s_ss_n;
  assign ss_rise     = !ss_prev_q && s_ss_n;
  assign sclk_rise   = !sclk_prev_q && s_sclk;
  assign sclk_fall   = sclk_prev_q && !s_sclk;
  assign lead_edge   = (cpol == CPOL_IDLE_LOW) ? sclk_rise : sclk_fall;
  assign trail_edge  = (cpol == CPOL_IDLE_LOW) ? sclk_fall : sclk_rise;
  assign sample_edge = (cpha == CPHA_LEAD) ? lead_edge : trail_edge;
  assign shift_edge  = (cpha == CPHA_LEAD) ? trail_edge : (lead_edge && (cnt_q != '0));

  always_comb begin
    state_d      = state_q;
    sclk_prev_d  = s_sclk;
    ss_prev_d    = s_ss_n;
    fill_d       = fill_done ? fill_q : fill_q + FW'(1);
    armed_d      = armed_q | (fill_done & s_ss_n);
    shreg_d      = shreg_q;
    rx_d         = rx_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    tx_full_d    = tx_full_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    underrun_d   = 1'b0;
    abort_d      = 1'b0;

    if (din_we) begin
      hold_d    = din;
      tx_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          rx_d    = '0;
          if (tx_full_q) begin
            shreg_d = hold_q;
            if (!din_we) tx_full_d = 1'b0;
          end else begin
            shreg_d    = '1;
            underrun_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else begin
          if (sample_edge && (cnt_q < CW'(WIDTH))) begin
            rx_d  = (rx_q << 1) | WIDTH'(s_mosi);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              dout_d       = rx_d;
              dout_valid_d = 1'b1;
              state_d      = ST_DONE;
            end
          end
          if (shift_edge) shreg_d = shreg_q << 1;
        end
      end
      ST_DONE: begin
        if (ss_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sclk_prev_q  <= 1'b0;
      ss_prev_q    <= 1'b1;
      fill_q       <= '0;
      armed_q      <= 1'b0;
      shreg_q      <= '0;
      rx_q         <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      tx_full_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_prev_q  <= sclk_prev_d;
      ss_prev_q    <= ss_prev_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      shreg_q      <= shreg_d;
      rx_q         <= rx_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      tx_full_q    <= tx_full_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      underrun_q   <= underrun_d;
      abort_q      <= abort_d;
    end
  end

  assign bus.miso    = (state_q != ST_IDLE) & shreg_q[WIDTH-1];
  assign bus.miso_oe = (state_q != ST_IDLE);
  assign tx_full     = tx_full_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign underrun    = underrun_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a task-based SPI master on clk/4 plus a dout scoreboard.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_we = 1'b0;
  logic       tx_full;
  logic [7:0] dout;
  logic       dout_valid;
  logic       underrun;
  logic       abort;
  logic [1:0] div = 2'd0;
  logic       clk4;

  spi_slave_if bus ();

  spi_slave #(.WIDTH(8), .SYNC(2)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .bus(bus),
    .din(din), .din_we(din_we), .tx_full(tx_full), .dout(dout),
    .dout_valid(dout_valid), .underrun(underrun), .abort(abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign clk4 = div[1];

  int n_assert = 0;
  int n_fail = 0;
  int dv_cnt = 0;
  int ur_cnt = 0;
  int ab_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every dout_valid pulse must match the oldest pushed word.
  always @(negedge clk) begin
    if (dout_valid) begin
      dv_cnt++;
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed dout %0h expected no pulse", dout);
      end
      if (exp_q.size() > 0) check("sb_dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      $display("xfer: dout=%02h", dout);
    end
    if (underrun) ur_cnt++;
    if (abort) ab_cnt++;
  end

  task automatic half();
    repeat (2) @(posedge clk4);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    din = v;
    din_we = 1'b1;
    @(negedge clk);
    din_we = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit hold_sel,
                          output logic [7:0] rx);
    rx = 8'h00;
    bus.sclk = cpol;
    half();
    bus.ss_n = 1'b0;
    bus.mosi = cpha ? 1'b0 : tx[7];
    half();
    half();
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        rx = {rx[6:0], bus.miso};
        bus.sclk = ~cpol;
        half();
        bus.sclk = cpol;
        if (i < 7) bus.mosi = tx[6-i];
        half();
      end else begin
        bus.sclk = ~cpol;
        bus.mosi = tx[7-i];
        half();
        rx = {rx[6:0], bus.miso};
        bus.sclk = cpol;
        half();
      end
    end
    if (!hold_sel) begin
      half();
      bus.ss_n = 1'b1;
      half();
      half();
    end
    @(negedge clk);
    $display("master: mode=%0d%0d sent=%02h bits=%0d got=%02h", cpol, cpha, tx, nbits, rx);
  endtask

  logic [7:0] rx;
  logic [7:0] dout_prev;
  logic       miso_h;
  int         dv0, ur0, ab0;

  initial begin
    bus.ss_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    #23;
    check("rst_miso", {31'd0, bus.miso}, 32'd0);
    check("rst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
    check("rst_tx_full", {31'd0, tx_full}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_pulses", {29'd0, dout_valid, underrun, abort}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      {cpol, cpha} = 2'(m);
      dv0 = dv_cnt; ur0 = ur_cnt;
      load(8'hB2);
      check("basic_tx_full_set", {31'd0, tx_full}, 32'd1);
      exp_q.push_back(8'hA1);
      spi_xfer(8'hA1, 8, 1'b0, rx);
      check("basic_miso_word", {24'd0, rx}, 32'h0000_00B2);
      check("basic_dv_once", dv_cnt - dv0, 32'd1);
      check("basic_tx_full_clr", {31'd0, tx_full}, 32'd0);
      check("basic_no_underrun", ur_cnt - ur0, 32'd0);
    end

    for (int m = 0; m < 4; m++) begin
      {cpol, cpha} = 2'(m);
      load(8'h62);
      check("b2b_full1", {31'd0, tx_full}, 32'd1);
      exp_q.push_back(8'h51);
      spi_xfer(8'h51, 8, 1'b0, rx);
      check("b2b_rx1", {24'd0, rx}, 32'h0000_0062);
      check("b2b_empty1", {31'd0, tx_full}, 32'd0);
      load(8'h51);
      check("b2b_full2", {31'd0, tx_full}, 32'd1);
      exp_q.push_back(8'h62);
      spi_xfer(8'h62, 8, 1'b0, rx);
      check("b2b_rx2", {24'd0, rx}, 32'h0000_0051);
      check("b2b_empty2", {31'd0, tx_full}, 32'd0);
    end

    {cpol, cpha} = 2'b00;
    ur0 = ur_cnt;
    exp_q.push_back(8'h3C);
    spi_xfer(8'h3C, 8, 1'b0, rx);
    check("underrun_once", ur_cnt - ur0, 32'd1);
    check("underrun_ones", {24'd0, rx}, 32'h0000_00FF);

    {cpol, cpha} = 2'b11;
    load(8'h99);
    dv0 = dv_cnt; ab0 = ab_cnt; dout_prev = dout;
    spi_xfer(8'h5A, 3, 1'b0, rx);
    check("abort_once", ab_cnt - ab0, 32'd1);
    check("abort_no_dv", dv_cnt - dv0, 32'd0);
    check("abort_dout_kept", {24'd0, dout}, {24'd0, dout_prev});
    check("abort_oe_off", {31'd0, bus.miso_oe}, 32'd0);

    {cpol, cpha} = 2'b00;
    load(8'h77);
    dv0 = dv_cnt; ur0 = ur_cnt; ab0 = ab_cnt;
    spi_xfer(8'h12, 4, 1'b1, rx);
    load(8'h44);
    rst_n = 1'b0;
    #1;
    check("midrst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
    check("midrst_miso", {31'd0, bus.miso}, 32'd0);
    check("midrst_tx_full", {31'd0, tx_full}, 32'd0);
    check("midrst_dout", {24'd0, dout}, 32'd0);
    repeat (4) @(negedge clk);
    bus.ss_n = 1'b1;
    bus.sclk = cpol;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_pulses", (dv_cnt - dv0) + (ur_cnt - ur0) + (ab_cnt - ab0), 32'd0);
    exp_q.push_back(8'hC3);
    spi_xfer(8'hC3, 8, 1'b0, rx);
    check("postrst_dout", {24'd0, dout}, 32'h0000_00C3);
    check("postrst_rx", {24'd0, rx}, 32'h0000_00FF);

    load(8'hE7);
    dv0 = dv_cnt; ab0 = ab_cnt;
    exp_q.push_back(8'h5D);
    spi_xfer(8'h5D, 8, 1'b1, rx);
    check("extra_rx", {24'd0, rx}, 32'h0000_00E7);
    miso_h = bus.miso;
    for (int k = 0; k < 4; k++) begin
      bus.sclk = ~bus.sclk;
      half();
    end
    check("extra_miso_held", {31'd0, bus.miso}, {31'd0, miso_h});
    check("extra_dv_once", dv_cnt - dv0, 32'd1);
    bus.ss_n = 1'b1;
    half();
    half();
    check("extra_no_abort", ab_cnt - ab0, 32'd0);
    check("extra_oe_off", {31'd0, bus.miso_oe}, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
